// File: rtl/gpio_bank_if.sv
// gpio_bank_if: Risco-5 data-bus slave port used by gpio_bank.
//   read, write   : one-cycle request pulses from the bus master
//   address       : byte address (the bank decodes address[5:2])
//   write_data    : write payload
//   read_data     : registered read data, 0 outside read responses
//   response      : one-cycle acknowledge, one cycle after the request
interface gpio_bank_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        response;

  modport master (
    output read, write, address, write_data,
    input  read_data, response
  );

  modport slave (
    input  read, write, address, write_data,
    output read_data, response
  );
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with per-pin direction/output registers,
// atomic set/clear/toggle, synchronised inputs and edge interrupts with
// write-1-to-clear pending bits.
//   clk, reset : clock, synchronous active-high reset
//   bus        : gpio_bank_if slave port (1-cycle latency, no stall)
//   gpio_in    : asynchronous pad inputs
//   gpio_out   : pad output values (OUT register)
//   gpio_oe    : pad output enables, 1 = drive (DIR register)
//   irq        : OR of all pending interrupt bits
module gpio_bank #(
  parameter int WIDTH       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  gpio_bank_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] OFF_DIR     = 4'h0;
  localparam logic [3:0] OFF_OUT     = 4'h1;
  localparam logic [3:0] OFF_OUT_SET = 4'h2;
  localparam logic [3:0] OFF_OUT_CLR = 4'h3;
  localparam logic [3:0] OFF_OUT_TGL = 4'h4;
  localparam logic [3:0] OFF_IN      = 4'h5;
  localparam logic [3:0] OFF_RISE_EN = 4'h6;
  localparam logic [3:0] OFF_FALL_EN = 4'h7;
  localparam logic [3:0] OFF_PEND    = 4'h8;

  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic             r_resp;
  logic [31:0]      r_rdata;

  logic [3:0]       w_off;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic             w_unused_bits;

  // Zero-extend a pin-wide value onto the 32-bit bus.
  function automatic logic [31:0] widen(input logic [WIDTH-1:0] v);
    logic [31:0] x;
    x           = '0;
    x[WIDTH-1:0] = v;
    return x;
  endfunction

  assign w_off   = bus.address[5:2];
  assign w_wdata = bus.write_data[WIDTH-1:0];
  assign w_in    = r_sync[SYNC_STAGES-1];

  // Address bits outside [5:2] and data bits above WIDTH are intentionally ignored.
  assign w_unused_bits = ^{bus.address[31:6], bus.address[1:0], bus.write_data};

  assign w_set = ((w_in & ~r_prev) & r_rise_en) | ((~w_in & r_prev) & r_fall_en);
  assign w_clr = (bus.write && (w_off == OFF_PEND)) ? w_wdata : '0;

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_DIR:     w_rdata = widen(r_dir);
      OFF_OUT:     w_rdata = widen(r_out);
      OFF_IN:      w_rdata = widen(w_in);
      OFF_RISE_EN: w_rdata = widen(r_rise_en);
      OFF_FALL_EN: w_rdata = widen(r_fall_en);
      OFF_PEND:    w_rdata = widen(r_pend);
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir     <= '0;
      r_out     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_pend    <= '0;
      r_resp    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_resp  <= bus.read | bus.write;
      // A combined read+write is treated as a write, so no data is returned.
      r_rdata <= (bus.read && !bus.write) ? w_rdata : 32'h0;
      if (bus.write) begin
        case (w_off)
          OFF_DIR:     r_dir     <= w_wdata;
          OFF_OUT:     r_out     <= w_wdata;
          OFF_OUT_SET: r_out     <= r_out | w_wdata;
          OFF_OUT_CLR: r_out     <= r_out & ~w_wdata;
          OFF_OUT_TGL: r_out     <= r_out ^ w_wdata;
          OFF_RISE_EN: r_rise_en <= w_wdata;
          OFF_FALL_EN: r_fall_en <= w_wdata;
          default:     ;
        endcase
      end
      // New edges win over a same-cycle write-1-to-clear.
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  assign gpio_out      = r_out;
  assign gpio_oe       = r_dir;
  assign irq           = |r_pend;
  assign bus.read_data = r_rdata;
  assign bus.response  = r_resp;

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;
  localparam int W = 20;
  localparam int S = 2;
  localparam logic [31:0] MASK = (W == 32) ? 32'hFFFF_FFFF : ((32'h1 << W) - 32'h1);

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  gpio_bank_if bus_if ();

  gpio_bank #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: register file as plain variables plus a history of
  // sampled pad values (index 0 = most recent edge).
  bit [31:0] m_dir, m_out, m_rise, m_fall, m_pend, m_rdata;
  bit        m_resp;
  bit [31:0] m_hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit [31:0] in_now, prev_now, set, clr, wd, rv;
    bit [3:0]  off;
    in_now   = (m_hist.size() >= S)     ? m_hist[S-1] : 32'h0;
    prev_now = (m_hist.size() >= S + 1) ? m_hist[S]   : 32'h0;
    if (reset) begin
      m_dir = 0; m_out = 0; m_rise = 0; m_fall = 0; m_pend = 0;
      m_resp = 0; m_rdata = 0;
      m_hist.delete();
      return;
    end
    off = bus_if.address[5:2];
    wd  = bus_if.write_data & MASK;
    set = ((in_now & ~prev_now) & m_rise) | ((~in_now & prev_now) & m_fall);
    clr = 0;
    rv  = 0;
    if (bus_if.read && !bus_if.write) begin
      case (off)
        4'h0: rv = m_dir;
        4'h1: rv = m_out;
        4'h5: rv = in_now;
        4'h6: rv = m_rise;
        4'h7: rv = m_fall;
        4'h8: rv = m_pend;
        default: rv = 0;
      endcase
    end
    if (bus_if.write) begin
      case (off)
        4'h0: m_dir  = wd;
        4'h1: m_out  = wd;
        4'h2: m_out  = m_out | wd;
        4'h3: m_out  = m_out & ~wd;
        4'h4: m_out  = m_out ^ wd;
        4'h6: m_rise = wd;
        4'h7: m_fall = wd;
        4'h8: clr    = wd;
        default: ;
      endcase
    end
    m_pend  = (m_pend & ~clr) | set;
    m_resp  = bus_if.read | bus_if.write;
    m_rdata = rv;
    m_hist.push_front(32'(gpio_in) & MASK);
    if (m_hist.size() > S + 1) void'(m_hist.pop_back());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gpio_out",  32'(gpio_out), m_out);
    chk("gpio_oe",   32'(gpio_oe),  m_dir);
    chk("irq",       32'(irq),      {31'b0, (m_pend != 0)});
    chk("response",  32'(bus_if.response), {31'b0, m_resp});
    chk("read_data", bus_if.read_data, m_rdata);
  endtask

  task automatic bus_rd(input logic [3:0] off, output logic [31:0] data);
    bus_if.read    = 1'b1;
    bus_if.write   = 1'b0;
    bus_if.address = {26'h0, off, 2'b00};
    step();
    data = bus_if.read_data;
    bus_if.read = 1'b0;
  endtask

  task automatic bus_wr(input logic [3:0] off, input logic [31:0] data);
    bus_if.read       = 1'b0;
    bus_if.write      = 1'b1;
    bus_if.address    = {26'h0, off, 2'b00};
    bus_if.write_data = data;
    step();
    bus_if.write = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] r32;
    reset = 1'b1;
    gpio_in = '0;
    bus_if.read = 1'b0;
    bus_if.write = 1'b0;
    bus_if.address = '0;
    bus_if.write_data = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset defaults: every offset reads 0
    for (int i = 0; i < 16; i++) begin
      bus_rd(i[3:0], rd);
      chk("rst_read", rd, 32'h0);
      chk("rst_resp", 32'(bus_if.response), 32'h1);
    end
    step();
    chk("rst_irq", 32'(irq), 32'h0);

    // Outputs
    bus_wr(4'h0, 32'hFFFF_FFFF);
    chk("oe_all", 32'(gpio_oe), 32'h000F_FFFF);
    bus_rd(4'h0, rd);
    chk("dir_rb", rd, 32'h000F_FFFF);
    bus_wr(4'h1, 32'h0000_00A5);
    bus_wr(4'h2, 32'h0000_0F00);
    bus_wr(4'h3, 32'h0000_0005);
    bus_wr(4'h4, 32'h0000_00F0);
    chk("out_seq", 32'(gpio_out), 32'h0000_0F50);
    bus_rd(4'h1, rd);
    chk("out_rb", rd, 32'h0000_0F50);
    bus_rd(4'h2, rd);
    chk("set_rd0", rd, 32'h0);

    // Input sync latency: pin 3 rises before edge N
    gpio_in = 20'h00008;
    bus_rd(4'h5, rd);
    chk("in_edgeN", rd & 32'h8, 32'h0);
    bus_rd(4'h5, rd);
    chk("in_edgeN1", rd & 32'h8, 32'h0);
    bus_rd(4'h5, rd);
    chk("in_after_N1", rd & 32'h8, 32'h8);

    // Edge interrupts
    gpio_in = 20'h00002;
    repeat (4) step();
    bus_wr(4'h6, 32'h1);
    bus_wr(4'h7, 32'h2);
    gpio_in = 20'h00001;
    repeat (4) step();
    bus_rd(4'h8, rd);
    chk("pend_both", rd, 32'h3);
    chk("irq_set", 32'(irq), 32'h1);
    bus_wr(4'h8, 32'h1);
    bus_rd(4'h8, rd);
    chk("pend_w1c0", rd, 32'h2);
    chk("irq_still", 32'(irq), 32'h1);
    bus_wr(4'h8, 32'h2);
    chk("irq_clear", 32'(irq), 32'h0);

    // Set wins over same-cycle clear
    gpio_in = 20'h0;
    repeat (4) step();
    bus_wr(4'h8, 32'hFFFF_FFFF);
    gpio_in = 20'h00001;
    step();
    step();
    bus_wr(4'h8, 32'h1);
    bus_rd(4'h8, rd);
    chk("collision", rd & 32'h1, 32'h1);

    // Read+write together, then reset in the response cycle
    bus_if.read = 1'b1;
    bus_if.write = 1'b1;
    bus_if.address = {26'h0, 4'h1, 2'b00};
    bus_if.write_data = 32'h0000_0123;
    step();
    bus_if.read = 1'b0;
    bus_if.write = 1'b0;
    chk("rw_resp", 32'(bus_if.response), 32'h1);
    chk("rw_rdata", bus_if.read_data, 32'h0);
    chk("rw_out", 32'(gpio_out), 32'h0000_0123);
    reset = 1'b1;
    step();
    chk("rst_mid_resp", 32'(bus_if.response), 32'h0);
    chk("rst_mid_out", 32'(gpio_out), 32'h0);
    chk("rst_mid_oe", 32'(gpio_oe), 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    step();
    // A request sampled together with reset is dropped
    bus_if.read = 1'b1;
    bus_if.address = {26'h0, 4'h0, 2'b00};
    reset = 1'b1;
    step();
    bus_if.read = 1'b0;
    reset = 1'b0;
    chk("rst_drop_resp", 32'(bus_if.response), 32'h0);
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      r32 = $urandom;
      if (r32[2:0] == 3'd0) gpio_in = gpio_in ^ W'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      r32 = $urandom;
      bus_if.read  = r32[0];
      bus_if.write = r32[1];
      bus_if.address = $urandom;
      if (r32[4:2] == 3'd0) bus_if.address[5:2] = 4'h8;
      bus_if.write_data = $urandom;
      step();
      bus_if.read = 1'b0;
      bus_if.write = 1'b0;
      reset = 1'b0;
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
